cp0_exception_ctrl: RTL and testbench
=====================================

Name: cp0_exception_ctrl

Overview:
- Sequences precise exception entry and return for the 5-stage MIPS pipeline. Owns the CP0 STATUS (reg 12), CAUSE (reg 13) and EPC (reg 14) registers.
- Prioritises competing exception sources from ID/EXE and the external interrupt, then drives the pipeline flush and PC redirect.
- Sits beside the ID/EXE stages and serves mfc0/mtc0.

Parameters:
- HANDLER_VEC, 32'h0000_0008, exception handler entry PC.
- IRQ_W, 6, number of hardware interrupt lines (maps to CAUSE.IP[15:10] and STATUS.IM[15:10]).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ext_int  in  IRQ_W  level interrupt requests
- id_syscall  in  1  syscall decoded in ID
- id_unknown  in  1  reserved instruction decoded in ID
- id_eret  in  1  eret decoded in ID
- exe_overflow  in  1  arithmetic overflow in EXE
- id_pc  in  32  PC of instruction in ID
- exe_pc  in  32  PC of instruction in EXE
- mtc0_we  in  1  CP0 write enable (from ID)
- cp0_addr  in  5  CP0 register index for mtc0/mfc0
- mtc0_wdata  in  32  CP0 write data
- mfc0_rdata  out  32  CP0 read data, combinational on cp0_addr
- flush_if_id  out  1  flush IF and ID stage registers
- flush_exe  out  1  flush EXE stage register
- redirect  out  1  PC load strobe
- redirect_pc  out  32  PC to load when redirect=1
- status  out  32  current STATUS
- cause  out  32  current CAUSE
- epc  out  32  current EPC

Behaviour:
- Reset values:
  - state=IDLE, status=32'h0000_0000, cause=0, epc=0, all strobes 0, redirect_pc=0.
- FSM states: IDLE (EXL=0), ENTER, HANDLER (EXL=1), RETURN.
- Event priority, evaluated each cycle in IDLE/HANDLER, highest first:
  - exe_overflow (ExcCode 12, EPC=exe_pc)
  - id_syscall (8, id_pc)
  - id_unknown (10, id_pc)
  - id_eret
  - interrupt (0, EPC=id_pc)
- Interrupt-taken condition: IDLE, STATUS.IE(bit0)=1, and |(cause.IP & status.IM) != 0.
- CAUSE.IP[15:10] is registered from ext_int every cycle (level, not latched). Software bits IP[9:8] are writable via mtc0.
- Exception taken, cycle N:
  - Registered update at edge N+1: EPC written (only if EXL was 0; nested exceptions in HANDLER keep the old EPC), CAUSE.ExcCode[6:2] set, STATUS.EXL(bit1) set to 1.
  - Next state ENTER.
- ENTER (one cycle):
  - redirect=1, redirect_pc=HANDLER_VEC, flush_if_id=1, flush_exe=1.
  - All event inputs ignored (they belong to squashed instructions).
  - Next state HANDLER.
- HANDLER:
  - id_eret (with no higher-priority event) -> STATUS.EXL cleared at the next edge; next state RETURN.
  - Interrupts are ignored while EXL=1.
- RETURN (one cycle):
  - redirect=1, redirect_pc=epc, flush_if_id=1, flush_exe=0.
  - Events ignored. Next state IDLE.
- id_eret in IDLE: the EXL bit is already 0; treat as return anyway (redirect to epc via RETURN).
- Redirect latency: exactly one cycle from event detection. Strobes are high for exactly one cycle.
- mtc0:
  - Applied at the edge when mtc0_we=1 and no event is taken that cycle. A taken event wins and the write is dropped.
  - Writable fields: STATUS bits [15:8] and [1:0]; CAUSE bits [9:8]; EPC bits [31:0]. Other bits read 0.
  - Writes in ENTER/RETURN are dropped.
- mfc0: addr 12/13/14 returns status/cause/epc. Any other address returns 0. Reads show the pre-edge value (no bypass).
- rst asserted mid-ENTER/RETURN: all state and outputs return to reset values at the next edge; no strobe is issued.

Decomposition:
- Shared package cp0_pkg: CP0 register indices (12/13/14), ExcCode constants (INT=0, SYS=8, RI=10, OV=12), STATUS/CAUSE bit positions, FSM state encoding.
- One sub-module, exc_priority_enc: combinational priority selection producing take, exc_code, epc_src, is_eret.

Test Plan:
- Overflow and syscall in the same cycle, exe_pc=0x40, id_pc=0x44 -> next cycle redirect=1, redirect_pc=0x08, both flushes=1; epc=0x40, cause[6:2]=12, status[1]=1.
- Unknown instruction at id_pc=0x100 -> handler entry, cause[6:2]=10. eret in HANDLER -> RETURN cycle with redirect_pc=0x100, flush_exe=0; status[1]=0; state back to IDLE.
- ext_int=6'b000001 with status=0x0000_0401 -> entry, ExcCode=0, epc=id_pc. Same stimulus with status IE=0 -> no redirect for 10 cycles.
- Nested syscall in HANDLER (epc=0x200) at id_pc=0x10 -> redirect to 0x08; epc stays 0x200; ExcCode=8.
- mtc0 to addr 14 with 0xDEAD_BEEC, then mfc0 addr 14 -> 0xDEAD_BEEC. mtc0 in the same cycle as exe_overflow -> write dropped.
- rst pulsed during ENTER -> redirect=0 on following cycles; status=cause=epc=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared constants and types for the CP0 exception controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] c_CP0_STATUS = 5'd12;
    localparam logic [4:0] c_CP0_CAUSE  = 5'd13;
    localparam logic [4:0] c_CP0_EPC    = 5'd14;

    // ExcCode values
    localparam logic [4:0] c_EXC_INT = 5'd0;
    localparam logic [4:0] c_EXC_SYS = 5'd8;
    localparam logic [4:0] c_EXC_RI  = 5'd10;
    localparam logic [4:0] c_EXC_OV  = 5'd12;

    // STATUS / CAUSE field positions
    localparam int c_ST_IE     = 0;
    localparam int c_ST_EXL    = 1;
    localparam int c_IM_LO     = 8;
    localparam int c_CA_EXC_LO = 2;
    localparam int c_IP_LO     = 8;
    localparam int c_IP_HW_LO  = 10;

    // Software-writable bits of each register
    localparam logic [31:0] c_STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] c_CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } cp0_state_e;

    typedef enum logic [0:0] {
        EPC_SRC_ID  = 1'b0,
        EPC_SRC_EXE = 1'b1
    } epc_src_e;

endpackage : cp0_pkg

`default_nettype wire

// File: rtl/exc_priority_enc.sv
// ============================================================================
//  Module      : exc_priority_enc
//  Description : Fixed-priority selection among exception/eret/interrupt events.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_priority_enc
    import cp0_pkg::*;
(
    input  logic       i_en,
    input  logic       i_exe_overflow,
    input  logic       i_id_syscall,
    input  logic       i_id_unknown,
    input  logic       i_id_eret,
    input  logic       i_irq,
    output logic       o_take,
    output logic [4:0] o_exc_code,
    output epc_src_e   o_epc_src,
    output logic       o_is_eret
);

    logic w_sync_exc;

    assign w_sync_exc = i_exe_overflow | i_id_syscall | i_id_unknown;

    always_comb begin
        o_take     = 1'b0;
        o_exc_code = c_EXC_INT;
        o_epc_src  = EPC_SRC_ID;
        o_is_eret  = 1'b0;
        if (i_en) begin
            if (i_exe_overflow) begin
                o_take     = 1'b1;
                o_exc_code = c_EXC_OV;
                o_epc_src  = EPC_SRC_EXE;
            end else if (i_id_syscall) begin
                o_take     = 1'b1;
                o_exc_code = c_EXC_SYS;
            end else if (i_id_unknown) begin
                o_take     = 1'b1;
                o_exc_code = c_EXC_RI;
            end else if (i_id_eret) begin
                o_take     = 1'b1;
                o_is_eret  = 1'b1;
            end else if (i_irq) begin
                o_take     = 1'b1;
                o_exc_code = c_EXC_INT;
            end
        end
        // Keeps the unused-looking OR reachable for readers tracing priority
        if (!w_sync_exc && !i_id_eret && !i_irq) begin
            o_take = 1'b0;
        end
    end

endmodule : exc_priority_enc

`default_nettype wire

// File: rtl/cp0_exception_ctrl.sv
// ============================================================================
//  Module      : cp0_exception_ctrl
//  Description : CP0 STATUS/CAUSE/EPC owner; sequences exception entry/return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0008,
    parameter int          IRQ_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] ext_int,
    input  logic             id_syscall,
    input  logic             id_unknown,
    input  logic             id_eret,
    input  logic             exe_overflow,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      exe_pc,
    input  logic             mtc0_we,
    input  logic [4:0]       cp0_addr,
    input  logic [31:0]      mtc0_wdata,
    output logic [31:0]      mfc0_rdata,
    output logic             flush_if_id,
    output logic             flush_exe,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      status,
    output logic [31:0]      cause,
    output logic [31:0]      epc
);

    cp0_state_e  r_state_q, w_state_d;
    logic [31:0] r_status_q, w_status_d;
    logic [31:0] r_cause_q, w_cause_d;
    logic [31:0] r_epc_q, w_epc_d;

    logic        w_events_live;
    logic        w_irq;
    logic        w_take;
    logic [4:0]  w_exc_code;
    epc_src_e    w_epc_src;
    logic        w_is_eret;
    logic [31:0] w_exc_pc;

    // ENTER/RETURN cycles carry squashed instructions, so events are masked there
    assign w_events_live = (r_state_q == ST_IDLE) || (r_state_q == ST_HANDLER);
    assign w_irq = (r_state_q == ST_IDLE) && r_status_q[c_ST_IE]
                   && (|(r_cause_q[15:8] & r_status_q[15:8]));

    exc_priority_enc u_prio (
        .i_en           (w_events_live),
        .i_exe_overflow (exe_overflow),
        .i_id_syscall   (id_syscall),
        .i_id_unknown   (id_unknown),
        .i_id_eret      (id_eret),
        .i_irq          (w_irq),
        .o_take         (w_take),
        .o_exc_code     (w_exc_code),
        .o_epc_src      (w_epc_src),
        .o_is_eret      (w_is_eret)
    );

    assign w_exc_pc = (w_epc_src == EPC_SRC_EXE) ? exe_pc : id_pc;

    always_comb begin
        w_state_d  = r_state_q;
        w_status_d = r_status_q;
        w_cause_d  = r_cause_q;
        w_epc_d    = r_epc_q;

        case (r_state_q)
            ST_IDLE, ST_HANDLER: begin
                if (w_take && w_is_eret) begin
                    w_status_d[c_ST_EXL] = 1'b0;
                    w_state_d            = ST_RETURN;
                end else if (w_take) begin
                    // Nested entries keep the EPC of the outermost exception
                    if (!r_status_q[c_ST_EXL]) begin
                        w_epc_d = w_exc_pc;
                    end
                    w_cause_d[c_CA_EXC_LO +: 5] = w_exc_code;
                    w_status_d[c_ST_EXL]        = 1'b1;
                    w_state_d                   = ST_ENTER;
                end else if (mtc0_we) begin
                    case (cp0_addr)
                        c_CP0_STATUS: w_status_d = (r_status_q & ~c_STATUS_WMASK)
                                                 | (mtc0_wdata & c_STATUS_WMASK);
                        c_CP0_CAUSE:  w_cause_d  = (r_cause_q & ~c_CAUSE_WMASK)
                                                 | (mtc0_wdata & c_CAUSE_WMASK);
                        c_CP0_EPC:    w_epc_d    = mtc0_wdata;
                        default:      ;
                    endcase
                end
            end
            ST_ENTER:  w_state_d = ST_HANDLER;
            ST_RETURN: w_state_d = ST_IDLE;
            default:   w_state_d = ST_IDLE;
        endcase

        // Hardware pending bits track the request lines every cycle
        w_cause_d[c_IP_HW_LO +: IRQ_W] = ext_int;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_status_q <= 32'h0;
            r_cause_q  <= 32'h0;
            r_epc_q    <= 32'h0;
        end else begin
            r_state_q  <= w_state_d;
            r_status_q <= w_status_d;
            r_cause_q  <= w_cause_d;
            r_epc_q    <= w_epc_d;
        end
    end

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        flush_if_id = 1'b0;
        flush_exe   = 1'b0;
        case (r_state_q)
            ST_ENTER: begin
                redirect    = 1'b1;
                redirect_pc = HANDLER_VEC;
                flush_if_id = 1'b1;
                flush_exe   = 1'b1;
            end
            ST_RETURN: begin
                redirect    = 1'b1;
                redirect_pc = r_epc_q;
                flush_if_id = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (cp0_addr)
            c_CP0_STATUS: mfc0_rdata = r_status_q;
            c_CP0_CAUSE:  mfc0_rdata = r_cause_q;
            c_CP0_EPC:    mfc0_rdata = r_epc_q;
            default:      mfc0_rdata = 32'h0;
        endcase
    end

    assign status = r_status_q;
    assign cause  = r_cause_q;
    assign epc    = r_epc_q;

endmodule : cp0_exception_ctrl

`default_nettype wire

// File: tb/tb_cp0_exception_ctrl.sv
// ============================================================================
//  Module      : tb_cp0_exception_ctrl
//  Description : Scoreboard bench for cp0_exception_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exception_ctrl;

    localparam logic [31:0] c_VEC = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int;
    logic        id_syscall, id_unknown, id_eret, exe_overflow;
    logic [31:0] id_pc, exe_pc;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic        flush_if_id, flush_exe, redirect;
    logic [31:0] redirect_pc, status, cause, epc;

    always #5 clk = ~clk;

    cp0_exception_ctrl #(.HANDLER_VEC(c_VEC), .IRQ_W(6)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int),
        .id_syscall(id_syscall), .id_unknown(id_unknown), .id_eret(id_eret),
        .exe_overflow(exe_overflow), .id_pc(id_pc), .exe_pc(exe_pc),
        .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_rdata(mfc0_rdata), .flush_if_id(flush_if_id), .flush_exe(flush_exe),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .status(status), .cause(cause), .epc(epc)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        fif;
        logic        fex;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: what phase of the exception protocol the core is in
    localparam int P_NORMAL = 0, P_ENTERING = 1, P_IN_HANDLER = 2, P_RETURNING = 3;
    int          m_phase  = P_NORMAL;
    logic [31:0] m_status = 0, m_cause = 0, m_epc = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    task automatic model_push();
        exp_t        e;
        logic        can_act, irq, exc, is_ov;
        logic [4:0]  code;
        logic [31:0] pc;
        if (rst) begin
            m_phase = P_NORMAL; m_status = 0; m_cause = 0; m_epc = 0;
        end else begin
            can_act = (m_phase == P_NORMAL) || (m_phase == P_IN_HANDLER);
            irq = (m_phase == P_NORMAL) && m_status[0]
                  && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
            exc = exe_overflow || id_syscall || id_unknown;
            is_ov = exe_overflow;
            code = exe_overflow ? 5'd12 : id_syscall ? 5'd8 : id_unknown ? 5'd10 : 5'd0;
            pc   = is_ov ? exe_pc : id_pc;
            if (can_act && (exc || (!id_eret && irq))) begin
                if (m_status[1] == 1'b0) m_epc = pc;
                m_cause = (m_cause & ~32'h7C) | ({27'h0, code} << 2);
                m_status = m_status | 32'h2;
                m_phase = P_ENTERING;
            end else if (can_act && id_eret) begin
                m_status = m_status & ~32'h2;
                m_phase = P_RETURNING;
            end else begin
                if (can_act && mtc0_we) begin
                    if (cp0_addr == 5'd12)
                        m_status = (m_status & ~32'hFF03) | (mtc0_wdata & 32'hFF03);
                    else if (cp0_addr == 5'd13)
                        m_cause = (m_cause & ~32'h300) | (mtc0_wdata & 32'h300);
                    else if (cp0_addr == 5'd14)
                        m_epc = mtc0_wdata;
                end
                if (m_phase == P_ENTERING)       m_phase = P_IN_HANDLER;
                else if (m_phase == P_RETURNING) m_phase = P_NORMAL;
            end
            m_cause = (m_cause & ~32'hFC00) | ({26'h0, ext_int} << 10);
        end
        e.redirect = (m_phase == P_ENTERING) || (m_phase == P_RETURNING);
        e.rpc = (m_phase == P_ENTERING) ? c_VEC : (m_phase == P_RETURNING) ? m_epc : 32'h0;
        e.fif = e.redirect;
        e.fex = (m_phase == P_ENTERING);
        e.st  = m_status;
        e.ca  = m_cause;
        e.ep  = m_epc;
        e.rd  = (cp0_addr == 5'd12) ? m_status : (cp0_addr == 5'd13) ? m_cause
              : (cp0_addr == 5'd14) ? m_epc : 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        model_push();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; id_syscall = 0; id_unknown = 0; id_eret = 0; exe_overflow = 0;
        mtc0_we = 0; cp0_addr = 5'd0; mtc0_wdata = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            quiet();
            cyc();
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        quiet(); mtc0_we = 1; cp0_addr = a; mtc0_wdata = d;
        cyc();
    endtask

    // Monitor: every sampled cycle with an outstanding expectation is compared
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("redirect",    {31'h0, redirect},    {31'h0, e.redirect});
                chk("redirect_pc", redirect_pc,          e.rpc);
                chk("flush_if_id", {31'h0, flush_if_id}, {31'h0, e.fif});
                chk("flush_exe",   {31'h0, flush_exe},   {31'h0, e.fex});
                chk("status",      status,               e.st);
                chk("cause",       cause,                e.ca);
                chk("epc",         epc,                  e.ep);
                chk("mfc0_rdata",  mfc0_rdata,           e.rd);
            end
        end
    end

    initial begin
        quiet(); rst = 1; ext_int = 0; id_pc = 0; exe_pc = 0;
        @(negedge clk); #1;
        rst = 1; cyc(); rst = 1; cyc();
        idle(2);

        // Overflow and syscall together: overflow wins
        quiet(); exe_overflow = 1; id_syscall = 1; exe_pc = 32'h40; id_pc = 32'h44;
        cyc();
        idle(3);
        quiet(); id_eret = 1; cyc();
        idle(2);

        // Reserved instruction then eret back to its PC
        quiet(); id_unknown = 1; id_pc = 32'h100; cyc();
        idle(2);
        quiet(); id_eret = 1; cyc();
        idle(2);

        // Interrupt with IE=1, IM bit 10 set
        mtc0(5'd12, 32'h0000_0401);
        ext_int = 6'b000001; id_pc = 32'h300;
        idle(4);
        ext_int = 0;
        idle(2);
        quiet(); id_eret = 1; cyc();
        idle(2);
        // Same request, IE cleared: no entry
        mtc0(5'd12, 32'h0000_0400);
        ext_int = 6'b000001;
        idle(10);
        ext_int = 0;
        idle(1);

        // Nested syscall keeps the outer EPC
        quiet(); id_syscall = 1; id_pc = 32'h200; cyc();
        idle(2);
        quiet(); id_syscall = 1; id_pc = 32'h10; cyc();
        idle(2);
        quiet(); id_eret = 1; cyc();
        idle(2);

        // mtc0/mfc0 on EPC, and a write colliding with an overflow
        mtc0(5'd14, 32'hDEAD_BEEC);
        quiet(); cp0_addr = 5'd14; cyc();
        quiet(); mtc0_we = 1; cp0_addr = 5'd14; mtc0_wdata = 32'h1234_5678;
        exe_overflow = 1; exe_pc = 32'h80; cyc();
        idle(2);
        quiet(); id_eret = 1; cyc();
        idle(2);

        // Reset during ENTER
        quiet(); id_syscall = 1; id_pc = 32'h500; cyc();
        quiet(); rst = 1; cyc();
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            quiet();
            rst          = ($urandom_range(0, 199) == 0);
            exe_overflow = ($urandom_range(0, 15) == 0);
            id_syscall   = ($urandom_range(0, 15) == 0);
            id_unknown   = ($urandom_range(0, 19) == 0);
            id_eret      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            id_pc  = $urandom & 32'hFFFF_FFFC;
            exe_pc = $urandom & 32'hFFFF_FFFC;
            mtc0_we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: cp0_addr = 5'd12;
                1: cp0_addr = 5'd13;
                2: cp0_addr = 5'd14;
                default: cp0_addr = 5'($urandom);
            endcase
            mtc0_wdata = $urandom;
            cyc();
        end
        idle(2);
        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cp0_exception_ctrl

`default_nettype wire
